// File: rtl/dbg_tl_master_if.sv
// TileLink-UL A/D channel bundle between the debug master and the bus.
// master: drives A, consumes D; slave: the opposite direction.
`ifndef TL_GET
`define TL_GET   3'd4
`endif
`ifndef TL_PUT_F
`define TL_PUT_F 3'd0
`endif
`ifndef TL_PUT_P
`define TL_PUT_P 3'd1
`endif

interface tilelink #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    a_valid;
  logic                    a_ready;
  logic [2:0]              a_opcode;
  logic [3:0]              a_size;
  logic [3:0]              a_source;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [DATA_WIDTH/8-1:0] a_mask;
  logic [DATA_WIDTH-1:0]   a_data;
  logic                    d_valid;
  logic                    d_ready;
  logic [DATA_WIDTH-1:0]   d_data;
  logic                    d_denied;
  logic                    d_corrupt;

  modport master (
    output a_valid, a_opcode, a_size, a_source,
    output a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_data,
    input  d_denied, d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source,
    input  a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_data,
    output d_denied, d_corrupt
  );
endinterface

// File: rtl/dbg_tl_master.sv
// Debug command to TileLink-UL single-beat get/put master with D timeout.
// Ports: clk, rst_n, cmd_* request, rsp_* response, bus (tilelink.master).
`ifndef TL_GET
`define TL_GET   3'd4
`endif
`ifndef TL_PUT_F
`define TL_PUT_F 3'd0
`endif
`ifndef TL_PUT_P
`define TL_PUT_P 3'd1
`endif

module dbg_tl_master #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH/8-1:0] cmd_mask,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  tilelink.master                 bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int          SIZE   = $clog2(DATA_WIDTH / 8);
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  logic [1:0]              state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH/8-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [15:0]             cnt_inc;

  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          mask_d  = cmd_mask;
          wdata_d = cmd_wdata;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.a_ready) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // A response in the final wait cycle beats the timeout.
        if (bus.d_valid) begin
          rdata_d = wr_q ? '0 : bus.d_data;
          err_d   = bus.d_denied | bus.d_corrupt;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_CNT) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Late D beats after a timeout are drained in IDLE.
  assign bus.d_ready   = (state_q == S_IDLE) || (state_q == S_RESP);
  assign bus.a_valid   = (state_q == S_REQ);
  assign bus.a_opcode  = !wr_q   ? `TL_GET :
                         &mask_q ? `TL_PUT_F : `TL_PUT_P;
  assign bus.a_size    = 4'(SIZE);
  assign bus.a_source  = 4'd0;
  assign bus.a_address = addr_q;
  assign bus.a_mask    = wr_q ? mask_q : '1;
  assign bus.a_data    = wr_q ? wdata_q : '0;

endmodule

// File: tb/tb_dbg_tl_master.sv
// Directed plus randomized bench for dbg_tl_master against a get/put model.
// Acts as the TileLink slave; checks A fields, D timing and responses.
module tb_dbg_tl_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [63:0] cmd_addr = '0;
  logic [7:0]  cmd_mask = '0;
  logic [63:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  tilelink #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  dbg_tl_master #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_mask(cmd_mask), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_a_valid"},   64'(bus.a_valid), 64'd0);
    chk({tag, "_d_ready"},   64'(bus.d_ready), 64'd1);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready),   64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid),   64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err),     64'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata,        64'd0);
  endtask

  // mode 0: normal D reply, 1: no D reply, 2: reset during the D wait
  task automatic txn(input logic w, input logic [63:0] addr,
                     input logic [7:0] mask, input logic [63:0] wd,
                     input int a_lat, input int d_lat,
                     input logic den, input logic cor,
                     input logic [63:0] dd, input int mode,
                     input int r_lat);
    logic [2:0]  e_op;
    logic [7:0]  e_mask;
    logic [63:0] e_data, e_rd;
    logic        e_err;
    int          n;
    e_op   = !w ? 3'd4 : (mask == 8'hFF ? 3'd0 : 3'd1);
    e_mask = w ? mask : 8'hFF;
    e_data = w ? wd : 64'd0;
    e_rd   = (mode == 1 || w) ? 64'd0 : dd;
    e_err  = (mode == 1) ? 1'b1 : (den | cor);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = addr;
    cmd_mask  = mask;
    cmd_wdata = wd;
    cyc();
    cmd_valid = 1'b0;
    cmd_addr  = ~addr;
    cmd_mask  = ~mask;
    cmd_wdata = ~wd;
    cmd_write = ~w;
    for (int i = 0; i <= a_lat; i++) begin
      chk("req_a_valid",   64'(bus.a_valid),  64'd1);
      chk("req_cmd_ready", 64'(cmd_ready),    64'd0);
      chk("req_d_ready",   64'(bus.d_ready),  64'd0);
      chk("req_opcode",    64'(bus.a_opcode), 64'(e_op));
      chk("req_addr",      bus.a_address,     addr);
      chk("req_mask",      64'(bus.a_mask),   64'(e_mask));
      chk("req_data",      bus.a_data,        e_data);
      chk("req_size",      64'(bus.a_size),   64'd3);
      chk("req_source",    64'(bus.a_source), 64'd0);
      if (i == a_lat) bus.a_ready = 1'b1;
      cyc();
    end
    bus.a_ready = 1'b0;
    chk("resp_a_valid", 64'(bus.a_valid), 64'd0);
    chk("resp_d_ready", 64'(bus.d_ready), 64'd1);
    if (mode == 1) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 400) begin
        cyc();
        n++;
      end
      chk("timeout_cycles", 64'(n), 64'd255);
    end else begin
      for (int i = 0; i < d_lat; i++) begin
        chk("resp_wait_rsp_valid", 64'(rsp_valid), 64'd0);
        cyc();
      end
      if (mode == 2) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_reset");
        cyc();
        rst_n = 1'b1;
        bus.d_valid = 1'b1;
        bus.d_data  = dd;
        cyc();
        bus.d_valid = 1'b0;
        chk_reset_outs("post_reset");
        return;
      end
      bus.d_valid   = 1'b1;
      bus.d_data    = dd;
      bus.d_denied  = den;
      bus.d_corrupt = cor;
      cyc();
      bus.d_valid   = 1'b0;
      bus.d_denied  = 1'b0;
      bus.d_corrupt = 1'b0;
      bus.d_data    = ~dd;
    end
    for (int i = 0; i <= r_lat; i++) begin
      chk("done_rsp_valid", 64'(rsp_valid),  64'd1);
      chk("done_rdata",     rsp_rdata,       e_rd);
      chk("done_err",       64'(rsp_err),    64'(e_err));
      chk("done_d_ready",   64'(bus.d_ready), 64'd0);
      chk("done_a_valid",   64'(bus.a_valid), 64'd0);
      chk("done_cmd_ready", 64'(cmd_ready),  64'd0);
      if (i == r_lat) begin
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
      end
      cyc();
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("after_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("after_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    logic        w;
    logic [7:0]  m;
    logic [63:0] dd;
    bus.a_ready   = 1'b0;
    bus.d_valid   = 1'b0;
    bus.d_data    = '0;
    bus.d_denied  = 1'b0;
    bus.d_corrupt = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("in_reset");
    rst_n = 1'b1;
    cyc();

    txn(1'b0, 64'h8000_0000, 8'h00, 64'hDEAD, 0, 1, 1'b0, 1'b0,
        64'h1122334455667788, 0, 0);
    txn(1'b1, 64'h1000, 8'hFF, 64'hCAFEF00D_12345678, 0, 0,
        1'b0, 1'b0, 64'h5555, 0, 0);
    txn(1'b1, 64'h1008, 8'h0F, 64'h0BAD_BEEF_0000_1111, 1, 2,
        1'b0, 1'b0, 64'h7777, 0, 1);
    txn(1'b0, 64'h2000, 8'h00, 64'h0, 10, 0, 1'b0, 1'b0,
        64'hA5A5_A5A5_5A5A_5A5A, 0, 0);
    txn(1'b0, 64'h3000, 8'h00, 64'h0, 0, 0, 1'b0, 1'b0,
        64'h0, 1, 0);

    bus.d_valid = 1'b1;
    bus.d_data  = 64'hFEED_FACE_0000_0001;
    cyc();
    bus.d_valid = 1'b0;
    chk("stray_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("stray_rdata",     rsp_rdata,      64'd0);
    chk("stray_err",       64'(rsp_err),   64'd1);
    chk("stray_cmd_ready", 64'(cmd_ready), 64'd1);

    txn(1'b0, 64'h4000, 8'h00, 64'h0, 0, 254, 1'b0, 1'b0,
        64'h0123_4567_89AB_CDEF, 0, 0);
    txn(1'b0, 64'h4800, 8'h00, 64'h0, 0, 0, 1'b1, 1'b0,
        64'h1111, 0, 0);
    txn(1'b1, 64'h5000, 8'hF0, 64'h9999, 0, 1, 1'b0, 1'b0,
        64'h0, 0, 5);
    txn(1'b0, 64'h6000, 8'h00, 64'h0, 0, 3, 1'b0, 1'b0,
        64'h2222, 2, 0);
    txn(1'b0, 64'h7000, 8'h00, 64'h0, 1, 1, 1'b0, 1'b0,
        64'h3333_4444_5555_6666, 0, 0);

    for (int k = 0; k < 16; k++) begin
      w  = 1'($urandom_range(0, 1));
      m  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      dd = {$urandom, $urandom};
      txn(w, {$urandom, $urandom}, m, {$urandom, $urandom},
          $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
          dd, 0, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbg_tl_master.md
DBG_TL_MASTER -- requirements
Module: dbg_tl_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, width of command and bus address.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, width of command and bus data; power of two, 8..64.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum number of cycles the block waits for a D response.
REQ-004 SHALL have port clk  input  1  single clock; every state update on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 SHALL have port cmd_valid  input  1  command present.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_write  input  1  1 = put, 0 = get.
REQ-009 SHALL have port cmd_addr  input  ADDR_WIDTH  target byte address.
REQ-010 SHALL have port cmd_mask  input  DATA_WIDTH/8  byte enables for a put.
REQ-011 SHALL have port cmd_wdata  input  DATA_WIDTH  put data.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-014 SHALL have port rsp_rdata  output  DATA_WIDTH  get data.
REQ-015 SHALL have port rsp_err  output  1  response is a timeout or a bus error.
REQ-016 SHALL have port bus  tilelink.master  --  initiator side, A and D channels; the block is the only initiator on this port.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, RESP, DONE.
REQ-018 cmd_ready SHALL be high only in IDLE; cmd_valid&&cmd_ready SHALL capture all cmd_* fields and move the FSM to REQ.
REQ-019 In REQ, a_valid SHALL be 1 and all A fields SHALL stay stable until a_ready; a_valid&&a_ready SHALL move the FSM to RESP.
REQ-020 a_opcode SHALL be `TL_GET for a read, `TL_PUT_F for a write with the mask all ones, and `TL_PUT_P for any other write.
REQ-021 a_size SHALL be log2(DATA_WIDTH/8); a_source SHALL be 0; a_address SHALL be the captured cmd_addr.
REQ-022 For a get, a_mask SHALL be all ones and a_data SHALL be 0.
REQ-023 In RESP, d_ready SHALL be 1; d_valid SHALL latch rsp_rdata (d_data for a get, 0 for a put) and rsp_err (d_denied or d_corrupt), then move the FSM to DONE.
REQ-024 A 16-bit wait counter SHALL clear on entry to RESP and increment each RESP cycle without d_valid.
REQ-025 When the counter reaches TIMEOUT, the FSM SHALL go to DONE with rsp_err=1 and rsp_rdata=0.
REQ-026 If d_valid arrives in the same cycle the counter reaches TIMEOUT, the response SHALL win and the timeout SHALL be ignored.
REQ-027 In DONE, rsp_valid SHALL be 1 with rsp_rdata and rsp_err stable; rsp_ready SHALL move the FSM to IDLE.
REQ-028 A new command SHALL NOT be accepted in the same cycle as rsp_ready; minimum command-to-command spacing is 4 cycles (IDLE, REQ, RESP, DONE).
REQ-029 In IDLE, d_ready SHALL be 1 and any d_valid (a late response after a timeout) SHALL be discarded with no effect on the outputs.
REQ-030 a_valid SHALL be 0 outside REQ; d_ready SHALL be 0 in REQ and DONE.

Reset
REQ-031 While rst_n=0 the FSM SHALL be in IDLE and the wait counter SHALL be 0.
REQ-032 While rst_n=0 the outputs SHALL be: a_valid=0, d_ready=1, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-033 A reset mid-transaction SHALL abandon that transaction with no response generated.

Verification
REQ-034 Get addr 0x8000_0000, slave returns d_data 0x1122334455667788 two cycles after the handshake -> `TL_GET, mask 0xFF; rsp_rdata 0x1122334455667788, rsp_err 0.
REQ-035 Put with mask 0xFF, then put with mask 0x0F -> a_opcode `TL_PUT_F, then `TL_PUT_P with a_mask 0x0F; both give rsp_err 0.
REQ-036 a_ready held low 10 cycles -> a_valid held for those cycles with A fields unchanged; cmd_ready 0 throughout.
REQ-037 No D response, TIMEOUT=255 -> rsp_valid with rsp_err 1 and rsp_rdata 0 exactly 255 RESP cycles after the A handshake; a later stray d_valid in IDLE is dropped.
REQ-038 rsp_ready held low 5 cycles, then rst_n pulsed low mid-RESP -> rsp_valid stable while waiting; after reset rsp_valid 0, cmd_ready 1, a_valid 0.
